// File: rtl/mul_approx_seq.sv
// -----------------------------------------------------------------------------
// mul_approx_seq
//   Sequential shift-add unsigned multiplier (WIDTH x WIDTH -> 2*WIDTH) with a
//   run-time selectable truncation depth. Each cycle in BUSY adds one partial
//   product. Partial-product bits in the lowest Keff columns are dropped
//   before accumulation, and carries out of those columns are lost. An
//   optional compensation constant 2^(Keff-1) is added at the end, with
//   saturation.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active-high
//   in_valid_i   operands and truncation depth are valid
//   in_ready_o   block can accept operands this cycle
//   a_i          multiplicand (WIDTH bits)
//   b_i          multiplier (WIDTH bits); one bit is consumed per cycle
//   k_i          requested truncation depth; clipped to TRUNC_MAX
//   out_valid_o  o_o holds a finished product
//   out_ready_i  consumer takes o_o
//   o_o          approximate product (2*WIDTH bits)
//   busy_o       multiplication in progress
// -----------------------------------------------------------------------------
module mul_approx_seq #(
  parameter int WIDTH     = 8,
  parameter int TRUNC_MAX = 8,
  parameter int COMP_EN   = 1,
  localparam int KW       = $clog2(2 * WIDTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic [KW-1:0]        k_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*WIDTH-1:0]   o_o,
  output logic                 busy_o
);

  localparam int PW        = 2 * WIDTH;
  localparam int CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int TMAX_CLIP = (TRUNC_MAX > PW) ? PW : TRUNC_MAX;
  localparam logic [KW-1:0] TMAX_K   = KW'(TMAX_CLIP);
  localparam logic [KW-1:0] PW_K     = KW'(PW);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]   keff_q, keff_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   o_q, o_d;
  logic            out_valid_q, out_valid_d;

  logic            accept;
  logic [KW-1:0]   keffIn;
  logic [PW-1:0]   ppFull;
  logic [PW-1:0]   colMask;
  logic [PW-1:0]   ppMasked;
  logic [PW-1:0]   accSum;
  logic [PW:0]     compVal;
  logic [PW:0]     finalSum;
  logic [PW-1:0]   finalSat;

  // A new operand set may enter while idle, or in DONE during the same cycle
  // the consumer takes the result, so back-to-back products need no bubble.
  assign in_ready_o  = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
  assign out_valid_o = out_valid_q;
  assign o_o         = o_q;
  assign busy_o      = (state_q == BUSY);

  // Datapath for the current BUSY cycle. The mask is applied to each partial
  // product on its own, so carries that dropped columns would have produced
  // never reach the kept columns. When Keff covers every column, the mask is
  // zero; this avoids a shift by the full vector width.
  always_comb begin
    accept   = in_valid_i && in_ready_o;
    keffIn   = (k_i > TMAX_K) ? TMAX_K : k_i;
    ppFull   = PW'(a_q) << cnt_q;
    colMask  = (keff_q >= PW_K) ? '0 : ({PW{1'b1}} << keff_q);
    ppMasked = b_q[cnt_q] ? (ppFull & colMask) : '0;
    accSum   = acc_q + ppMasked;
    compVal  = '0;
    if ((COMP_EN != 0) && (keff_q != '0)) begin
      compVal = (PW + 1)'(1) << (keff_q - KW'(1));
    end
    finalSum = {1'b0, accSum} + compVal;
    finalSat = finalSum[PW] ? {PW{1'b1}} : finalSum[PW-1:0];
  end

  // Next-state and register-update logic. Operands are captured only on
  // accept, so input changes while busy have no effect. The result register
  // changes only on the completing edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    keff_d      = keff_q;
    acc_d       = acc_q;
    o_d         = o_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = a_i;
          b_d     = b_i;
          keff_d  = keffIn;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        acc_d = accSum;
        if (cnt_q == LAST_CNT) begin
          o_d         = finalSat;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          if (accept) begin
            a_d     = a_i;
            b_d     = b_i;
            keff_d  = keffIn;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any product in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      keff_q      <= '0;
      acc_q       <= '0;
      o_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      keff_q      <= keff_d;
      acc_q       <= acc_d;
      o_q         <= o_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_mul_approx_seq.sv
// -----------------------------------------------------------------------------
// tb_mul_approx_seq
//   Self-checking bench for mul_approx_seq. Three instances share one stimulus
//   stream:
//     dutC: TRUNC_MAX=8,  COMP_EN=1
//     dutE: TRUNC_MAX=8,  COMP_EN=0
//     dutF: TRUNC_MAX=16, COMP_EN=1 (can reach full-width truncation)
//   Expected products are pushed to a scoreboard queue when operands are
//   accepted. They are popped when the product appears.
// -----------------------------------------------------------------------------
module tb_mul_approx_seq;

   localparam int W  = 8;
   localparam int KW = 5;

   logic clk = 1'b0;
   logic rst;
   logic inValid;
   logic outReady;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [KW-1:0] k;

   logic inReadyC, outValidC, busyC;
   logic inReadyE, outValidE, busyE;
   logic inReadyF, outValidF, busyF;
   logic [2*W-1:0] oC, oE, oF;

   typedef struct {
      int oC;
      int oE;
      int oF;
   } exp_t;

   exp_t sb[$];
   int compared = 0;
   int mismatched = 0;
   int cycleCount = 0;
   int acceptCycle = 0;

   mul_approx_seq #(.WIDTH(W), .TRUNC_MAX(8), .COMP_EN(1)) dutC (
      .clk_i(clk), .rst_i(rst), .in_valid_i(inValid), .in_ready_o(inReadyC),
      .a_i(a), .b_i(b), .k_i(k), .out_valid_o(outValidC),
      .out_ready_i(outReady), .o_o(oC), .busy_o(busyC)
   );

   mul_approx_seq #(.WIDTH(W), .TRUNC_MAX(8), .COMP_EN(0)) dutE (
      .clk_i(clk), .rst_i(rst), .in_valid_i(inValid), .in_ready_o(inReadyE),
      .a_i(a), .b_i(b), .k_i(k), .out_valid_o(outValidE),
      .out_ready_i(outReady), .o_o(oE), .busy_o(busyE)
   );

   mul_approx_seq #(.WIDTH(W), .TRUNC_MAX(16), .COMP_EN(1)) dutF (
      .clk_i(clk), .rst_i(rst), .in_valid_i(inValid), .in_ready_o(inReadyF),
      .a_i(a), .b_i(b), .k_i(k), .out_valid_o(outValidF),
      .out_ready_i(outReady), .o_o(oF), .busy_o(busyF)
   );

   // Free-running clock with a 10 ns period.
   always #5 clk = ~clk;

   // Count rising edges so that latency can be measured from the accept edge.
   always @(posedge clk) cycleCount++;

   // Reference model. Each partial product is masked separately, and the sum
   // wraps at 16 bits. The compensation constant is then added, and the result
   // saturates.
   function automatic int modelMul(input int aa, input int bb, input int kk,
                                   input int tmax, input bit comp);
      int keff;
      int acc;
      int pp;
      keff = (kk > tmax) ? tmax : kk;
      acc = 0;
      for (int i = 0; i < W; i++) begin
         if (bb[i]) begin
            pp = (aa << i) & ~((1 << keff) - 1);
            acc = (acc + pp) & 32'hFFFF;
         end
      end
      if (comp && keff > 0) acc = acc + (1 << (keff - 1));
      if (acc > 65535) acc = 65535;
      return acc;
   endfunction

   // One comparison. A mismatch is counted and reported.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Entered and left just after a falling edge. Drives one operand set,
   // which is accepted at the next rising edge, and records what each
   // instance must produce.
   task automatic applyStimulus(input int aa, input int bb, input int kk,
                                input int eC, input int eE, input int eF);
      exp_t e;
      inValid = 1'b1;
      a = aa[W-1:0];
      b = bb[W-1:0];
      k = kk[KW-1:0];
      #1;
      check("in_ready", {31'd0, inReadyC}, 32'd1);
      e.oC = eC;
      e.oE = eE;
      e.oF = eF;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      inValid = 1'b0;
      a = ~a;
      b = ~b;
      k = ~k;
      acceptCycle = cycleCount;
      #1;
      check("busy_after_accept", {31'd0, busyC}, 32'd1);
      check("valid_low_in_busy", {31'd0, outValidC}, 32'd0);
   endtask

   // Waits, with a bound, for the product. Checks the latency and compares
   // all three instances against the popped scoreboard entry. Does not
   // consume the product.
   task automatic checkOutput();
      exp_t e;
      int n;
      n = 0;
      while (outValidC !== 1'b1 && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("out_valid", {31'd0, outValidC}, 32'd1);
      check("latency", cycleCount - acceptCycle, W);
      if (sb.size() == 0) begin
         check("scoreboard_nonempty", sb.size(), 1);
      end else begin
         e = sb.pop_front();
         check("o_comp", {16'd0, oC}, e.oC);
         check("o_exact_comp_off", {16'd0, oE}, e.oE);
         check("o_full_trunc", {16'd0, oF}, e.oF);
         check("busy_done", {31'd0, busyC}, 32'd0);
         check("out_valid_E", {31'd0, outValidE}, 32'd1);
         check("out_valid_F", {31'd0, outValidF}, 32'd1);
      end
   endtask

   // Hands the product to the consumer for one edge. The block must then be
   // idle and ready again.
   task automatic consume();
      outReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      outReady = 1'b0;
      #1;
      check("valid_drop", {31'd0, outValidC}, 32'd0);
      check("ready_idle", {31'd0, inReadyC}, 32'd1);
   endtask

   initial begin : stimulus
      logic [15:0] held;
      int aa, bb, kk, stall;

      rst = 1'b1;
      inValid = 1'b0;
      outReady = 1'b0;
      a = '0;
      b = '0;
      k = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", {31'd0, outValidC}, 32'd0);
      check("rst_o", {16'd0, oC}, 32'd0);
      check("rst_busy", {31'd0, busyC}, 32'd0);
      check("rst_in_ready", {31'd0, inReadyC}, 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // Exact product.
      applyStimulus(255, 255, 0, 65025, 65025, 65025);
      checkOutput();
      consume();

      // K=4 on 15x15. The kept partial products are 0+16+48+112 = 176.
      // The compensation constant is 8, which gives 184.
      applyStimulus(15, 15, 4, 184, 176, 184);
      checkOutput();
      consume();

      // K=20 clips to 8 on the TRUNC_MAX=8 instances. There the masked
      // partial products sum to 256*(2^i - 1) over i=0..7 = 63232, and the
      // compensation constant adds 128. On the TRUNC_MAX=16 instance, Keff=16
      // drops every column, leaving only 2^15.
      applyStimulus(255, 255, 20, 63360, 63232, 32768);
      checkOutput();
      consume();

      // Full-width truncation requested directly.
      applyStimulus(255, 255, 16, 63360, 63232, 32768);
      checkOutput();
      consume();

      // The consumer stalls for five cycles. After that, a new accept
      // happens on the same edge that consumes the product.
      applyStimulus(100, 200, 3, modelMul(100, 200, 3, 8, 1),
                    modelMul(100, 200, 3, 8, 0), modelMul(100, 200, 3, 16, 1));
      checkOutput();
      held = oC;
      repeat (5) begin
         @(negedge clk);
         #1;
         check("stall_valid", {31'd0, outValidC}, 32'd1);
         check("stall_o", {16'd0, oC}, {16'd0, held});
         check("stall_in_ready", {31'd0, inReadyC}, 32'd0);
      end
      outReady = 1'b1;
      applyStimulus(7, 9, 0, 63, 63, 63);
      outReady = 1'b0;
      checkOutput();

      // Reset during BUSY aborts the product and clears the held result
      // immediately.
      outReady = 1'b1;
      applyStimulus(200, 100, 0, 20000, 20000, 20000);
      outReady = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", {31'd0, busyC}, 32'd0);
      check("abort_valid", {31'd0, outValidC}, 32'd0);
      check("abort_o", {16'd0, oC}, 32'd0);
      check("abort_in_ready", {31'd0, inReadyC}, 32'd1);
      void'(sb.pop_back());
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      applyStimulus(3, 5, 0, 15, 15, 15);
      checkOutput();
      consume();

      // Random operands and depths against the model. The consumer stall
      // before each consume is also random.
      for (int n = 0; n < 1000; n++) begin
         aa = $urandom_range(0, 255);
         bb = $urandom_range(0, 255);
         kk = $urandom_range(0, 31);
         applyStimulus(aa, bb, kk, modelMul(aa, bb, kk, 8, 1),
                       modelMul(aa, bb, kk, 8, 0), modelMul(aa, bb, kk, 16, 1));
         checkOutput();
         stall = $urandom_range(0, 2);
         repeat (stall) @(negedge clk);
         #1;
         consume();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
